// File: rtl/glyph_renderer.sv
// Framebuffer renderer: draws hex glyph pairs into a back buffer one glyph row per clock,
// then swaps the finished frame atomically into the registered front buffer.

module letter_stuff (
    input  logic [7:0]  letter,
    output logic [14:0] left_glyph,
    output logic [14:0] right_glyph
);
    // 3x5 hex font, bit 14 is the top-left pixel, row-major, 3 bits per row
    function automatic logic [14:0] font(input logic [3:0] digit);
        case (digit)
            4'h0:    font = 15'b111_101_101_101_111;
            4'h1:    font = 15'b010_110_010_010_111;
            4'h2:    font = 15'b111_001_111_100_111;
            4'h3:    font = 15'b111_001_111_001_111;
            4'h4:    font = 15'b101_101_111_001_001;
            4'h5:    font = 15'b111_100_111_001_111;
            4'h6:    font = 15'b111_100_111_101_111;
            4'h7:    font = 15'b111_001_001_001_001;
            4'h8:    font = 15'b111_101_111_101_111;
            4'h9:    font = 15'b111_101_111_001_111;
            4'hA:    font = 15'b111_101_111_101_101;
            4'hB:    font = 15'b110_101_110_101_110;
            4'hC:    font = 15'b111_100_100_100_111;
            4'hD:    font = 15'b110_101_101_101_110;
            4'hE:    font = 15'b111_100_111_100_111;
            default: font = 15'b111_100_111_100_100;
        endcase
    endfunction

    assign left_glyph  = font(letter[7:4]);
    assign right_glyph = font(letter[3:0]);
endmodule

module glyph_renderer #(
    parameter int WIDTH       = 40,
    parameter int HEIGHT      = 30,
    parameter int NUM_SPRITES = 3,
    parameter int X_BASE      = 6,
    parameter int X_STEP      = 10,
    parameter int Y_BASE      = 2,
    parameter int HIDE_Y      = 22
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [8*NUM_SPRITES-1:0]  letters,
    input  logic [5*NUM_SPRITES-1:0]  ypos,
    input  logic [NUM_SPRITES-1:0]    enable,
    output logic                      busy,
    output logic                      frame_done,
    output logic [WIDTH*HEIGHT-1:0]   framebuffer
);
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int SPR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(HEIGHT - 1);
    localparam logic [SPR_W-1:0] LAST_SPRITE = SPR_W'(NUM_SPRITES - 1);

    generate
        if (X_BASE + (NUM_SPRITES - 1) * X_STEP + 8 > WIDTH) begin : g_bad_geometry
            $error("glyph_renderer: rightmost sprite does not fit inside WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, SWAP} state_t;
    state_t state, next_state;

    logic [8*NUM_SPRITES-1:0] shadow_letters;
    logic [5*NUM_SPRITES-1:0] shadow_ypos;
    logic [NUM_SPRITES-1:0]   shadow_enable;
    logic [WIDTH*HEIGHT-1:0]  back_buffer;
    logic [ROW_W-1:0]         clear_row;
    logic [SPR_W-1:0]         sprite_cnt;
    logic [2:0]               glyph_row;

    logic [7:0]  cur_letter;
    logic [4:0]  cur_ypos;
    logic        cur_enable;
    logic [14:0] left_glyph;
    logic [14:0] right_glyph;
    logic [7:0]  row_bits;
    logic        draw_ok;
    int          glyph_msb;
    int          target_row;
    int          draw_base;

    letter_stuff u_font (
        .letter      (cur_letter),
        .left_glyph  (left_glyph),
        .right_glyph (right_glyph)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = CLEAR;
            CLEAR: if (clear_row == LAST_ROW) next_state = DRAW;
            DRAW:  if (sprite_cnt == LAST_SPRITE && glyph_row == 3'd4) next_state = SWAP;
            SWAP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Each glyph's leftmost pixel lands on the highest column of its 3-bit field
    always_comb begin
        cur_letter = shadow_letters[8*sprite_cnt +: 8];
        cur_ypos   = shadow_ypos[5*sprite_cnt +: 5];
        cur_enable = shadow_enable[sprite_cnt];
        glyph_msb  = 14 - 3 * int'(glyph_row);
        row_bits   = {right_glyph[glyph_msb -: 3], 2'b00, left_glyph[glyph_msb -: 3]};
        target_row = Y_BASE + int'(cur_ypos) + int'(glyph_row);
        draw_base  = target_row * WIDTH + X_BASE + int'(sprite_cnt) * X_STEP;
        draw_ok    = cur_enable && (int'(cur_ypos) < HIDE_Y) && (target_row < HEIGHT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_letters <= '0;
            shadow_ypos    <= '0;
            shadow_enable  <= '0;
            back_buffer    <= '0;
            framebuffer    <= '0;
            frame_done     <= 1'b0;
            clear_row      <= '0;
            sprite_cnt     <= '0;
            glyph_row      <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow_letters <= letters;
                        shadow_ypos    <= ypos;
                        shadow_enable  <= enable;
                        clear_row      <= '0;
                        sprite_cnt     <= '0;
                        glyph_row      <= '0;
                    end
                end
                CLEAR: begin
                    back_buffer[int'(clear_row) * WIDTH +: WIDTH] <= '0;
                    clear_row <= clear_row + 1'b1;
                end
                DRAW: begin
                    if (draw_ok)
                        back_buffer[draw_base +: 8] <= back_buffer[draw_base +: 8] | row_bits;
                    if (glyph_row == 3'd4) begin
                        glyph_row  <= '0;
                        sprite_cnt <= sprite_cnt + 1'b1;
                    end else begin
                        glyph_row <= glyph_row + 3'd1;
                    end
                end
                SWAP: begin
                    framebuffer <= back_buffer;
                    frame_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_glyph_renderer.sv
// Bench for glyph_renderer: directed and random frames compared against a pixel-level
// picture model built from the font table and sprite placement rules.

module tb_glyph_renderer;
    localparam int WIDTH       = 40;
    localparam int HEIGHT      = 30;
    localparam int NUM_SPRITES = 3;
    localparam int X_BASE      = 6;
    localparam int X_STEP      = 10;
    localparam int Y_BASE      = 2;
    localparam int HIDE_Y      = 22;
    localparam int NBITS       = WIDTH * HEIGHT;
    localparam int LATENCY     = HEIGHT + 5 * NUM_SPRITES + 1;

    logic                     clock;
    logic                     reset_n;
    logic                     start;
    logic [8*NUM_SPRITES-1:0] letters;
    logic [5*NUM_SPRITES-1:0] ypos;
    logic [NUM_SPRITES-1:0]   enable;
    logic                     busy;
    logic                     frame_done;
    logic [NBITS-1:0]         framebuffer;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [NBITS-1:0] expected;
    int               latency;
    int               pulses;

    // Pixels listed top-left first, three per row
    logic [14:0] font_px [16] = '{
        15'b111_101_101_101_111, 15'b010_110_010_010_111,
        15'b111_001_111_100_111, 15'b111_001_111_001_111,
        15'b101_101_111_001_001, 15'b111_100_111_001_111,
        15'b111_100_111_101_111, 15'b111_001_001_001_001,
        15'b111_101_111_101_111, 15'b111_101_111_001_111,
        15'b111_101_111_101_101, 15'b110_101_110_101_110,
        15'b111_100_100_100_111, 15'b110_101_101_101_110,
        15'b111_100_111_100_111, 15'b111_100_111_100_100
    };

    glyph_renderer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_SPRITES(NUM_SPRITES),
        .X_BASE(X_BASE), .X_STEP(X_STEP), .Y_BASE(Y_BASE), .HIDE_Y(HIDE_Y)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .letters     (letters),
        .ypos        (ypos),
        .enable      (enable),
        .busy        (busy),
        .frame_done  (frame_done),
        .framebuffer (framebuffer)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [NBITS-1:0] model_frame(input logic [8*NUM_SPRITES-1:0] let_v,
                                                     input logic [5*NUM_SPRITES-1:0] yp_v,
                                                     input logic [NUM_SPRITES-1:0] en_v);
        logic [NBITS-1:0] fb;
        logic [3:0]       digit;
        int               y0;
        int               xf;
        int               row;
        fb = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            y0 = int'(yp_v[5*i +: 5]);
            if (en_v[i] && y0 < HIDE_Y) begin
                for (int half = 0; half < 2; half++) begin
                    digit = (half == 0) ? let_v[8*i+4 +: 4] : let_v[8*i +: 4];
                    xf    = X_BASE + i * X_STEP + 5 * half;
                    for (int r = 0; r < 5; r++) begin
                        row = Y_BASE + y0 + r;
                        for (int c = 0; c < 3; c++)
                            if (row < HEIGHT && font_px[digit][14 - 3*r - c])
                                fb[row * WIDTH + xf + 2 - c] = 1'b1;
                    end
                end
            end
        end
        return fb;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic checkFrame(input string tag, input logic [NBITS-1:0] exp);
        int first;
        first = -1;
        for (int i = NBITS - 1; i >= 0; i--)
            if (framebuffer[i] !== exp[i]) first = i;
        checks_total++;
        assert (framebuffer === exp) checks_passed++;
        else $error("FAIL %s: framebuffer has %0d bits set, expected %0d; first difference at row %0d col %0d",
                    tag, $countones(framebuffer), $countones(exp), first / WIDTH, first % WIDTH);
    endtask

    task automatic randomInputs();
        letters = (8*NUM_SPRITES)'($urandom);
        enable  = NUM_SPRITES'($urandom);
        for (int i = 0; i < NUM_SPRITES; i++)
            ypos[5*i +: 5] = 5'($urandom_range(0, 25));
    endtask

    // The edge inside this task is T0
    task automatic applyStimulus();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Iteration k drives values sampled at edge T0+k; returns k of the frame_done edge
    task automatic runToDone(input bit poke_starts, input int scramble_at, output int lat);
        lat = -1;
        for (int k = 1; k <= LATENCY + 20; k++) begin
            start = poke_starts && (k == 5 || k == 20 || k == 45);
            if (k == scramble_at) randomInputs();
            tick();
            start = 1'b0;
            if (frame_done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic countPulses(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (frame_done !== 1'b0) n++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        letters = '0;
        ypos    = '0;
        enable  = '0;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", frame_done, 0);
        checkFrame("reset_fb", '0);
        reset_n = 1'b1;
        countPulses(100, pulses);
        checkOutput("idle_pulses", pulses, 0);
        checkOutput("idle_busy", busy, 0);
        checkFrame("idle_fb", '0);

        // Single '88' pair in sprite 0 at the top
        letters  = 24'h000088;
        ypos     = '0;
        enable   = 3'b001;
        expected = model_frame(letters, ypos, enable);
        applyStimulus();
        checkOutput("busy_after_start", busy, 1);
        runToDone(1'b0, -1, latency);
        checkOutput("latency_88", latency, LATENCY);
        checkFrame("frame_88", expected);
        checkOutput("pix_r2c6", framebuffer[2*WIDTH + 6], 1);
        checkOutput("pix_r3c7", framebuffer[3*WIDTH + 7], 0);
        tick();
        checkOutput("done_one_cycle", frame_done, 0);
        checkOutput("busy_after_swap", busy, 0);

        // Sprite 1 at the last visible offset, then just hidden
        letters  = 24'h00FF00;
        ypos     = 15'(21 << 5);
        enable   = 3'b010;
        expected = model_frame(letters, ypos, enable);
        applyStimulus();
        runToDone(1'b0, -1, latency);
        checkOutput("latency_y21", latency, LATENCY);
        checkFrame("frame_y21", expected);
        checkOutput("row23_bits", framebuffer[23*WIDTH + 16 +: 8], 8'hE7);
        checkOutput("row24_bits", framebuffer[24*WIDTH + 16 +: 8], 8'h84);
        ypos = 15'(22 << 5);
        applyStimulus();
        runToDone(1'b0, -1, latency);
        checkOutput("latency_y22", latency, LATENCY);
        checkFrame("frame_y22_hidden", '0);

        // Starts while busy are dropped; a start right after frame_done is taken
        randomInputs();
        expected = model_frame(letters, ypos, enable);
        applyStimulus();
        runToDone(1'b1, -1, latency);
        checkOutput("latency_ignored_starts", latency, LATENCY);
        checkFrame("frame_ignored_starts", expected);
        randomInputs();
        expected = model_frame(letters, ypos, enable);
        applyStimulus();
        checkOutput("b2b_done_low", frame_done, 0);
        checkOutput("b2b_busy", busy, 1);
        runToDone(1'b0, -1, latency);
        checkOutput("latency_b2b", latency, LATENCY);
        checkFrame("frame_b2b", expected);

        // Inputs change mid-render; the latched values still win
        randomInputs();
        expected = model_frame(letters, ypos, enable);
        applyStimulus();
        runToDone(1'b0, 10, latency);
        checkOutput("latency_scramble", latency, LATENCY);
        checkFrame("frame_scramble", expected);

        for (int n = 0; n < 6; n++) begin
            tick();
            randomInputs();
            expected = model_frame(letters, ypos, enable);
            applyStimulus();
            runToDone(1'b0, -1, latency);
            checkOutput($sformatf("latency_rand%0d", n), latency, LATENCY);
            checkFrame($sformatf("frame_rand%0d", n), expected);
        end

        // Mid-render reset abandons the frame and clears the visible buffer
        letters  = 24'h123456;
        ypos     = '0;
        enable   = 3'b111;
        expected = model_frame(letters, ypos, enable);
        applyStimulus();
        runToDone(1'b0, -1, latency);
        checkFrame("frame_before_reset", expected);
        applyStimulus();
        repeat (29) tick();
        reset_n = 1'b0;
        #1;
        checkFrame("midreset_fb", '0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", frame_done, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        countPulses(60, pulses);
        checkOutput("after_reset_pulses", pulses, 0);
        checkOutput("after_reset_busy", busy, 0);
        randomInputs();
        expected = model_frame(letters, ypos, enable);
        applyStimulus();
        runToDone(1'b0, -1, latency);
        checkOutput("latency_after_reset", latency, LATENCY);
        checkFrame("frame_after_reset", expected);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
